multi_cycle_alu_core: RTL and testbench
=======================================

# multi_cycle_alu_core

Multi-cycle integer execution core that accepts one 32-bit RV32I/RV64I ALU instruction at a time over a valid/ready handshake. It reads operands from an internal register file, executes OP (R-type) and OP-IMM (I-type) operations, writes the result back and reports each retirement on a retire port. It is the parametrised successor to the single-cycle ALU datapath, generalised in data width and register count. It adds sign-extended immediates, full funct7 decoding, illegal-instruction reporting, a hardwired-zero x0 and a retirement counter.

## Interface
- XLEN, 32: datapath and register width; legal values 32, 64.
- REG_COUNT, 32: architectural registers; legal values 16 (E-variant), 32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  core can accept an instruction.
- in_instr  input  32  instruction word.
- retire_valid  output  1  one-cycle pulse per finished instruction.
- retire_illegal  output  1  qualifies retire_valid; instruction was rejected.
- retire_rd  output  5  destination register of the retired instruction.
- retire_data  output  XLEN  value written (0 if illegal or rd=0).
- retired_count  output  32  count of legal retirements; wraps.
- dbg_addr  input  5  debug register-read address.
- dbg_data  output  XLEN  combinational read of register dbg_addr; 0 for x0 or out-of-range.

## Operation
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_instr and go to DECODE. in_ready is 0 in all other states.
- DECODE:
  - Latch rs1 and rs2 (or the immediate) into operand registers.
  - Immediate = sign-extend(instr[31:20]) to XLEN.
  - Evaluate legality, then go to EXECUTE.
- Legal opcodes are 0010011 (OP-IMM) and 0110011 (OP). Anything else is illegal.
- OP decoding: funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA). All other funct7 values are illegal.
- OP-IMM decoding:
  - funct3 001 (SLLI) requires instr[31:26]=000000.
  - funct3 101 requires instr[31:26]=000000 (SRLI) or 010000 (SRAI).
  - When XLEN=32, instr[25] must be 0 for both.
  - Other funct3 values are always legal.
- Register range: rd, rs1 or rs2 ≥ REG_COUNT makes the instruction illegal. For OP-IMM, rs2 is not checked.
- Shift amount = low $clog2(XLEN) bits of rs2 value (OP) or of instr[25:20] (OP-IMM).
- SLT is signed and SLTU unsigned; results are 0 or 1, zero-extended. All arithmetic wraps modulo 2^XLEN.
- EXECUTE: compute the result into result_q, then go to WRITEBACK. For serial shifts see Configuration.
- WRITEBACK:
  - If legal and rd≠0, write result_q to rd.
  - Pulse retire_valid.
  - If legal, increment retired_count.
  - Go to IDLE.
- Illegal instruction: no register write, retire_illegal=1, retire_data=0, retired_count unchanged.
- x0 always reads 0; writes to it are discarded. retire_data is 0 when rd=0.

## Timing
- Reset values:
  - State IDLE, in_ready=1.
  - retire_valid, retire_illegal, retire_rd, retire_data and retired_count all 0.
  - All registers 0.
- Reset wins over any simultaneous handshake. Reset asserted mid-instruction abandons it: no write, no retire.
- Handshake at edge N means DECODE in cycle N+1, EXECUTE in N+2, WRITEBACK in N+3. retire_valid is high in the cycle after edge N+3; in_ready is high again in that same cycle.
- Base latency is 4 cycles per instruction, giving a peak throughput of one instruction per 4 cycles.
- All retire outputs are registered and hold their value until the next retirement. retire_valid is high for exactly one cycle.
- dbg_data reflects a write on the cycle after the WRITEBACK edge.
- An instruction whose rs1 equals the previous rd sees the new value; no hazard exists because execution is sequential.

## Configuration
- ALU_SERIAL_SHIFT_EN defined:
  - Shifts run serially. EXECUTE loads a shift counter with the shift amount and shifts result_q by one bit per cycle until the counter is 0; SRA fills with the sign bit.
  - EXECUTE lasts max(1, shamt) cycles, so shift latency is 3+max(1,shamt).
  - Non-shift operations are unaffected.
- ALU_SERIAL_SHIFT_EN undefined: single-cycle barrel shifter; every instruction takes exactly 4 cycles.

## Test plan
- Reset, then ADDI x1,x0,-5 (0xFFB00093) → retire in cycle 4, x1=0xFFFFFFFB, retired_count=1, dbg_data(1)=0xFFFFFFFB.
- x1=7, x2=9: SUB x3,x1,x2 → x3=0xFFFFFFFE. SLT x4,x1,x2 → 1. SLTU x5,x3,x1 → 0.
- SRAI x6,x3,4 → 0xFFFFFFFF. With ALU_SERIAL_SHIFT_EN, retire_valid arrives 7 cycles after the handshake instead of 4.
- ADDI x0,x0,5 → retire_rd=0, retire_data=0, dbg_data(0)=0. Opcode 0000011 → retire_illegal=1, no register change, retired_count unchanged.
- Hold in_valid high continuously with back-to-back ADDIs → exactly one handshake per 4 cycles. Assert reset during EXECUTE → no retire, in_ready=1 the next cycle, registers 0.
- REG_COUNT=16: ADD x17,x1,x2 → illegal. XLEN=64: SLLI with instr[25]=1 and shamt 33 → legal, 1<<33.

Source files
------------

// File: rtl/multi_cycle_alu_core.sv
// multi_cycle_alu_core: sequential RV32I/RV64I OP / OP-IMM execution core.
// One instruction in flight; IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Optional macro ALU_SERIAL_SHIFT_EN: shifts execute one bit per cycle
// instead of using a barrel shifter.
module multi_cycle_alu_core #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            retire_valid,
    output logic            retire_illegal,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic [31:0]     retired_count,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int         SHW       = $clog2(XLEN);
    localparam int         IDXW      = $clog2(REG_COUNT);
    localparam logic [5:0] LP_REGS   = 6'(REG_COUNT);
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

    state_t                 r_state, w_next;
    logic [31:0]            r_instr;
    logic [XLEN-1:0]        r_op_a, r_op_b, r_result;
    logic                   r_illegal;
    logic [XLEN-1:0]        r_regs [REG_COUNT];
    logic                   r_retire_valid, r_retire_illegal;
    logic [4:0]             r_retire_rd;
    logic [XLEN-1:0]        r_retire_data;
    logic [31:0]            r_retired_count;

    logic [6:0]             w_opcode, w_f7;
    logic [4:0]             w_rd, w_rs1, w_rs2;
    logic [2:0]             w_f3;
    logic [XLEN-1:0]        w_imm, w_rs1_val, w_rs2_val, w_alu, w_dbg;
    logic signed [XLEN-1:0] w_a_s, w_b_s;
    logic [SHW-1:0]         w_shamt;
    logic                   w_enc_ok, w_range_ok, w_shift_ok, w_legal, w_exec_done;

`ifdef ALU_SERIAL_SHIFT_EN
    logic [SHW-1:0]         r_cnt;
    logic                   r_busy;
    logic                   w_is_shift, w_left, w_arith;

    // One-bit shift step; arithmetic right shift replicates the sign bit.
    function automatic logic [XLEN-1:0] f_shift1(input logic [XLEN-1:0] v,
                                                 input logic left, input logic arith);
        if (left)
            return {v[XLEN-2:0], 1'b0};
        return {arith & v[XLEN-1], v[XLEN-1:1]};
    endfunction
`endif

    function automatic logic f_in_range(input logic [4:0] a);
        return {1'b0, a} < LP_REGS;
    endfunction

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_f3     = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_f7     = r_instr[31:25];
    assign w_imm    = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_a_s    = r_op_a;
    assign w_b_s    = r_op_b;
    // Both the OP rs2 value and the OP-IMM immediate carry shamt in their low bits.
    assign w_shamt  = r_op_b[SHW-1:0];
    assign in_ready = (r_state == S_IDLE);

    assign retire_valid   = r_retire_valid;
    assign retire_illegal = r_retire_illegal;
    assign retire_rd      = r_retire_rd;
    assign retire_data    = r_retire_data;
    assign retired_count  = r_retired_count;
    assign dbg_data       = w_dbg;

    // Register file reads for operand fetch and the debug port.
    always_comb begin
        w_rs1_val = r_regs[w_rs1[IDXW-1:0]];
        w_rs2_val = r_regs[w_rs2[IDXW-1:0]];
        w_dbg     = '0;
        if (dbg_addr != 5'd0 && f_in_range(dbg_addr))
            w_dbg = r_regs[dbg_addr[IDXW-1:0]];
    end

    // Legality of the latched instruction: opcode, funct fields, register range.
    always_comb begin
        w_shift_ok = (XLEN == 64) || !r_instr[25];
        w_range_ok = f_in_range(w_rd) && f_in_range(w_rs1) &&
                     ((w_opcode == OPC_OPIMM) || f_in_range(w_rs2));
        w_enc_ok   = 1'b0;
        case (w_opcode)
            OPC_OPIMM: begin
                case (w_f3)
                    3'b001:  w_enc_ok = (r_instr[31:26] == 6'b000000) && w_shift_ok;
                    3'b101:  w_enc_ok = ((r_instr[31:26] == 6'b000000) ||
                                         (r_instr[31:26] == 6'b010000)) && w_shift_ok;
                    default: w_enc_ok = 1'b1;
                endcase
            end
            OPC_OP: begin
                if (w_f7 == 7'b0000000)
                    w_enc_ok = 1'b1;
                else if (w_f7 == 7'b0100000)
                    w_enc_ok = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            end
            default: w_enc_ok = 1'b0;
        endcase
        w_legal = w_enc_ok && w_range_ok;
    end

    // Single-cycle ALU result; instr[30] selects SUB (OP only) and SRA/SRAI.
    always_comb begin
        w_alu = '0;
        case (w_f3)
            3'b000:  w_alu = ((w_opcode == OPC_OP) && r_instr[30]) ? r_op_a - r_op_b
                                                                   : r_op_a + r_op_b;
            3'b001:  w_alu = r_op_a << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (r_op_a < r_op_b)};
            3'b100:  w_alu = r_op_a ^ r_op_b;
            3'b101:  w_alu = r_instr[30] ? $unsigned(w_a_s >>> w_shamt) : (r_op_a >> w_shamt);
            3'b110:  w_alu = r_op_a | r_op_b;
            default: w_alu = r_op_a & r_op_b;
        endcase
    end

    // EXECUTE completion: immediate unless a serial shift still has bits to go.
    always_comb begin
`ifdef ALU_SERIAL_SHIFT_EN
        w_is_shift  = !r_illegal && ((w_f3 == 3'b001) || (w_f3 == 3'b101));
        w_left      = (w_f3 == 3'b001);
        w_arith     = (w_f3 == 3'b101) && r_instr[30];
        w_exec_done = !(w_is_shift && (r_busy ? (r_cnt != SHW'(1)) : (w_shamt > SHW'(1))));
`else
        w_exec_done = 1'b1;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (in_valid) w_next = S_DECODE;
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE:   if (w_exec_done) w_next = S_WRITEBACK;
            default:     w_next = S_IDLE;
        endcase
    end

    // Datapath, register file and retire port; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr          <= '0;
            r_op_a           <= '0;
            r_op_b           <= '0;
            r_result         <= '0;
            r_illegal        <= 1'b0;
            r_retire_valid   <= 1'b0;
            r_retire_illegal <= 1'b0;
            r_retire_rd      <= '0;
            r_retire_data    <= '0;
            r_retired_count  <= '0;
            for (int i = 0; i < REG_COUNT; i++)
                r_regs[i] <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
            r_cnt            <= '0;
            r_busy           <= 1'b0;
`endif
        end else begin
            r_retire_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid)
                        r_instr <= in_instr;
                end
                S_DECODE: begin
                    r_op_a    <= w_rs1_val;
                    r_op_b    <= (w_opcode == OPC_OP) ? w_rs2_val : w_imm;
                    r_illegal <= !w_legal;
                end
                S_EXECUTE: begin
`ifdef ALU_SERIAL_SHIFT_EN
                    if (w_is_shift) begin
                        if (!r_busy) begin
                            r_result <= (w_shamt == '0) ? r_op_a : f_shift1(r_op_a, w_left, w_arith);
                            r_cnt    <= (w_shamt == '0) ? '0 : w_shamt - SHW'(1);
                            r_busy   <= (w_shamt > SHW'(1));
                        end else begin
                            r_result <= f_shift1(r_result, w_left, w_arith);
                            r_cnt    <= r_cnt - SHW'(1);
                            if (r_cnt == SHW'(1))
                                r_busy <= 1'b0;
                        end
                    end else begin
                        r_result <= w_alu;
                    end
`else
                    r_result <= w_alu;
`endif
                end
                default: begin
                    if (!r_illegal && w_rd != 5'd0)
                        r_regs[w_rd[IDXW-1:0]] <= r_result;
                    r_retire_valid   <= 1'b1;
                    r_retire_illegal <= r_illegal;
                    r_retire_rd      <= w_rd;
                    r_retire_data    <= (r_illegal || w_rd == 5'd0) ? '0 : r_result;
                    if (!r_illegal)
                        r_retired_count <= r_retired_count + 32'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_alu_core.sv
// Bench for multi_cycle_alu_core: directed vector table plus hand sequences
// for back-to-back issue, reset mid-instruction and the XLEN=64/REG_COUNT=16 build.
module tb_multi_cycle_alu_core;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        ill;
        logic [31:0] cnt;
        int          shamt;   // -1 for non-shift instructions
        logic [63:0] dbg;     // expected register rd after retirement
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid0, in_valid1;
    logic [31:0] in_instr;
    logic [4:0]  dbg_addr;
    bit          sel;

    logic        rdy0, rv0, ril0;
    logic [4:0]  rrd0;
    logic [31:0] rdat0, rcnt0, dbg0;
    logic        rdy1, rv1, ril1;
    logic [4:0]  rrd1;
    logic [63:0] rdat1, dbg1;
    logic [31:0] rcnt1;

    logic        m_ready, m_rvalid, m_ill;
    logic [4:0]  m_rd;
    logic [63:0] m_rdata, m_dbg;
    logic [31:0] m_cnt;

    int n_vec = 0;
    int miscompares = 0;

    multi_cycle_alu_core #(.XLEN(32), .REG_COUNT(32)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(rdy0),
        .in_instr(in_instr), .retire_valid(rv0), .retire_illegal(ril0),
        .retire_rd(rrd0), .retire_data(rdat0), .retired_count(rcnt0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0));

    multi_cycle_alu_core #(.XLEN(64), .REG_COUNT(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(rdy1),
        .in_instr(in_instr), .retire_valid(rv1), .retire_illegal(ril1),
        .retire_rd(rrd1), .retire_data(rdat1), .retired_count(rcnt1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1));

    assign m_ready  = sel ? rdy1 : rdy0;
    assign m_rvalid = sel ? rv1  : rv0;
    assign m_ill    = sel ? ril1 : ril0;
    assign m_rd     = sel ? rrd1 : rrd0;
    assign m_rdata  = sel ? rdat1 : {32'd0, rdat0};
    assign m_dbg    = sel ? dbg1  : {32'd0, dbg0};
    assign m_cnt    = sel ? rcnt1 : rcnt0;

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_latency(input int shamt);
`ifdef ALU_SERIAL_SHIFT_EN
        if (shamt < 0) return 4;
        return 3 + ((shamt < 1) ? 1 : shamt);
`else
        return 4 + 0 * shamt;
`endif
    endfunction

    // Issue one instruction to the selected DUT and check its retirement.
    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        int   w;
        logic got;
        @(negedge clk);
        in_instr = v.instr;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        w = 0;
        while (!m_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = m_rvalid;
        end
        n_vec++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s.timeout: no retire_valid within %0d cycles", nm, lat);
        end else begin
            chk({nm, ".illegal"}, 64'(m_ill), 64'(v.ill));
            chk({nm, ".rd"},      64'(m_rd),  64'(v.rd));
            chk({nm, ".data"},    m_rdata,    v.data);
            chk({nm, ".count"},   64'(m_cnt), 64'(v.cnt));
            chk({nm, ".latency"}, 64'(lat),   64'(exp_latency(v.shamt)));
            dbg_addr = v.rd;
            #1;
            chk({nm, ".dbg"}, m_dbg, v.dbg);
            @(negedge clk);
            chk({nm, ".pulse"}, 64'(m_rvalid), 64'd0);
            chk({nm, ".hold"},  m_rdata, v.data);
        end
    endtask

    vec_t tab [16];
    vec_t tab64 [3];

    initial begin
        int hs;
        int last;
        logic seen;

        tab[0]  = '{32'hFFB00093, 5'd1,  64'hFFFFFFFB, 1'b0, 32'd1,  -1, 64'hFFFFFFFB}; // ADDI x1,x0,-5
        tab[1]  = '{32'h00700093, 5'd1,  64'h7,        1'b0, 32'd2,  -1, 64'h7};        // ADDI x1,x0,7
        tab[2]  = '{32'h00900113, 5'd2,  64'h9,        1'b0, 32'd3,  -1, 64'h9};        // ADDI x2,x0,9
        tab[3]  = '{32'h402081B3, 5'd3,  64'hFFFFFFFE, 1'b0, 32'd4,  -1, 64'hFFFFFFFE}; // SUB x3,x1,x2
        tab[4]  = '{32'h0020A233, 5'd4,  64'h1,        1'b0, 32'd5,  -1, 64'h1};        // SLT x4,x1,x2
        tab[5]  = '{32'h0011B2B3, 5'd5,  64'h0,        1'b0, 32'd6,  -1, 64'h0};        // SLTU x5,x3,x1
        tab[6]  = '{32'h4041D313, 5'd6,  64'hFFFFFFFF, 1'b0, 32'd7,   4, 64'hFFFFFFFF}; // SRAI x6,x3,4
        tab[7]  = '{32'h00500013, 5'd0,  64'h0,        1'b0, 32'd8,  -1, 64'h0};        // ADDI x0,x0,5
        tab[8]  = '{32'h0000A383, 5'd7,  64'h0,        1'b1, 32'd8,  -1, 64'h0};        // LW: illegal
        tab[9]  = '{32'h002093B3, 5'd7,  64'hE00,      1'b0, 32'd9,   9, 64'hE00};      // SLL x7,x1,x2
        tab[10] = '{32'h0021D433, 5'd8,  64'h007FFFFF, 1'b0, 32'd10,  9, 64'h007FFFFF}; // SRL x8,x3,x2
        tab[11] = '{32'h402093B3, 5'd7,  64'h0,        1'b1, 32'd10, -1, 64'hE00};      // funct7 0100000 + SLL
        tab[12] = '{32'h02109493, 5'd9,  64'h0,        1'b1, 32'd10, -1, 64'h0};        // SLLI instr[25]=1
        tab[13] = '{32'hFFF0C493, 5'd9,  64'hFFFFFFF8, 1'b0, 32'd11, -1, 64'hFFFFFFF8}; // XORI x9,x1,-1
        tab[14] = '{32'h4021D533, 5'd10, 64'hFFFFFFFF, 1'b0, 32'd12,  9, 64'hFFFFFFFF}; // SRA x10,x3,x2
        tab[15] = '{32'h0F01F593, 5'd11, 64'hF0,       1'b0, 32'd13, -1, 64'hF0};       // ANDI x11,x3,0xF0

        tab64[0] = '{32'h00100093, 5'd1,  64'h1,           1'b0, 32'd1, -1, 64'h1};           // ADDI x1,x0,1
        tab64[1] = '{32'h02109113, 5'd2,  64'h200000000,   1'b0, 32'd2, 33, 64'h200000000};   // SLLI x2,x1,33
        tab64[2] = '{32'h002088B3, 5'd17, 64'h0,           1'b1, 32'd2, -1, 64'h0};           // ADD x17: out of range

        reset = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; in_instr = '0; dbg_addr = 5'd1; sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        chk("reset.in_ready", 64'(rdy0), 64'd1);
        chk("reset.retire_valid", 64'(rv0), 64'd0);
        chk("reset.retire_illegal", 64'(ril0), 64'd0);
        chk("reset.retire_rd", 64'(rrd0), 64'd0);
        chk("reset.retire_data", 64'(rdat0), 64'd0);
        chk("reset.count", 64'(rcnt0), 64'd0);
        chk("reset.dbg1", 64'(dbg0), 64'd0);

        for (int i = 0; i < 16; i++)
            run_vec(tab[i], $sformatf("vec%0d", i));

        // Back-to-back ADDI x12,x12,1 with in_valid held high.
        @(negedge clk);
        in_instr = 32'h00160613;
        in_valid0 = 1'b1;
        hs = 0;
        last = -1;
        for (int cyc = 0; cyc < 60 && hs < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rdy0) begin
                if (last >= 0)
                    chk($sformatf("b2b.spacing%0d", hs), 64'(cyc - last), 64'd4);
                last = cyc;
                hs++;
            end
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++;
        chk("b2b.handshakes", 64'(hs), 64'd5);
        dbg_addr = 5'd12;
        #1;
        chk("b2b.x12", 64'(dbg0), 64'd5);
        chk("b2b.count", 64'(rcnt0), 64'd18);

        // XLEN=64, REG_COUNT=16 instance.
        sel = 1'b1;
        for (int i = 0; i < 3; i++)
            run_vec(tab64[i], $sformatf("x64_%0d", i));
        sel = 1'b0;

        // Reset during EXECUTE, held across an IDLE edge with in_valid high.
        @(negedge clk);
        in_instr = 32'h00100693;     // ADDI x13,x0,1
        in_valid0 = 1'b1;
        @(posedge clk);              // handshake
        @(negedge clk);              // DECODE
        @(negedge clk);              // EXECUTE
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        chk("rstmid.in_ready", 64'(rdy0), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        in_valid0 = 1'b0;
        #1;
        chk("rstmid.in_ready_after", 64'(rdy0), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rv0) seen = 1'b1;
        end
        chk("rstmid.no_retire", 64'(seen), 64'd0);
        chk("rstmid.count", 64'(rcnt0), 64'd0);
        chk("rstmid.retire_data", 64'(rdat0), 64'd0);
        dbg_addr = 5'd13;
        #1;
        chk("rstmid.x13", 64'(dbg0), 64'd0);
        dbg_addr = 5'd1;
        #1;
        chk("rstmid.x1", 64'(dbg0), 64'd0);
        chk("rstmid.x1_64", dbg1, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
